// File: rtl/mc_ctrl.sv
// Multicycle main controller: decodes the latched instruction and walks it through
// fetch/decode/execute/memory/write-back, driving every datapath enable and select.

module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [2:0] ALUctrl,
  output logic       BSel,
  output logic       ExtOp,
  output logic [1:0] WRSel,
  output logic       WDSel,
  output logic [1:0] NPCOp,
  output logic       retire,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ADDU = 3'd0,
    C_SUBU = 3'd1,
    C_ORI  = 3'd2,
    C_LW   = 3'd3,
    C_SW   = 3'd4,
    C_BEQ  = 3'd5,
    C_ILL  = 3'd6
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  // Anything outside the supported subset is classified illegal and runs as a NOP.
  function automatic iclass_t decode_instr(input logic [5:0] op_v, input logic [5:0] funct_v);
    iclass_t c;
    c = C_ILL;
    case (op_v)
      OP_RTYPE: begin
        case (funct_v)
          FN_ADDU: c = C_ADDU;
          FN_SUBU: c = C_SUBU;
          default: c = C_ILL;
        endcase
      end
      OP_ORI:  c = C_ORI;
      OP_LW:   c = C_LW;
      OP_SW:   c = C_SW;
      OP_BEQ:  c = C_BEQ;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  iclass_t    iclass_s;
  logic [2:0] alu_s;
  logic       bsel_s;
  logic       extop_s;
  logic [1:0] wrsel_s;
  logic       wdsel_s;

  assign iclass_s = decode_instr(op, funct);
  assign state    = state_r;

  // Per-instruction datapath selects, held from EXE until the instruction retires.
  always_comb begin
    alu_s   = 3'b000;
    bsel_s  = 1'b0;
    extop_s = 1'b0;
    wrsel_s = 2'b00;
    wdsel_s = 1'b0;
    case (iclass_s)
      C_ADDU: begin
        alu_s   = 3'b001;
        wrsel_s = 2'b01;
      end
      C_SUBU: begin
        alu_s   = 3'b011;
        wrsel_s = 2'b01;
      end
      C_ORI: begin
        alu_s  = 3'b010;
        bsel_s = 1'b1;
      end
      C_LW: begin
        alu_s   = 3'b110;
        bsel_s  = 1'b1;
        extop_s = 1'b1;
        wdsel_s = 1'b1;
      end
      C_SW: begin
        alu_s   = 3'b111;
        bsel_s  = 1'b1;
        extop_s = 1'b1;
      end
      C_BEQ: begin
        alu_s   = 3'b101;
        extop_s = 1'b1;
      end
      default: begin
        alu_s = 3'b000;
      end
    endcase
  end

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state sequencing.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: next_state_s = S_DECODE;
      S_DECODE: begin
        case (iclass_s)
          C_BEQ:   next_state_s = S_BRANCH;
          C_ILL:   next_state_s = S_FETCH;
          default: next_state_s = S_EXE;
        endcase
      end
      S_EXE: begin
        case (iclass_s)
          C_LW:    next_state_s = S_MEM_RD;
          C_SW:    next_state_s = S_MEM_WR;
          default: next_state_s = S_WB;
        endcase
      end
      S_MEM_RD: next_state_s = S_WB;
      S_MEM_WR: next_state_s = S_FETCH;
      S_WB:     next_state_s = S_FETCH;
      S_BRANCH: next_state_s = S_FETCH;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Output decode; reset forces every control output low regardless of state.
  always_comb begin
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    ALUctrl = 3'b000;
    BSel    = 1'b0;
    ExtOp   = 1'b0;
    WRSel   = 2'b00;
    WDSel   = 1'b0;
    NPCOp   = 2'b00;
    retire  = 1'b0;
    if (!rst) begin
      case (state_r)
        S_FETCH: begin
          PCWr = 1'b1;
          IRWr = 1'b1;
        end
        S_DECODE: begin
          retire = (iclass_s == C_ILL);
        end
        S_EXE, S_MEM_RD: begin
          ALUctrl = alu_s;
          BSel    = bsel_s;
          ExtOp   = extop_s;
          WRSel   = wrsel_s;
          WDSel   = wdsel_s;
        end
        S_MEM_WR: begin
          ALUctrl = alu_s;
          BSel    = bsel_s;
          ExtOp   = extop_s;
          WRSel   = wrsel_s;
          WDSel   = wdsel_s;
          DMWr    = 1'b1;
          retire  = 1'b1;
        end
        S_WB: begin
          ALUctrl = alu_s;
          BSel    = bsel_s;
          ExtOp   = extop_s;
          WRSel   = wrsel_s;
          WDSel   = wdsel_s;
          RFWr    = 1'b1;
          retire  = 1'b1;
        end
        S_BRANCH: begin
          // Target is relative to PC+4, which FETCH already wrote back.
          ALUctrl = 3'b101;
          ExtOp   = 1'b1;
          NPCOp   = 2'b01;
          PCWr    = zero;
          retire  = 1'b1;
        end
        default: begin
          retire = 1'b0;
        end
      endcase
    end else begin
      ALUctrl = 3'b000;
    end
  end

endmodule

// Property checker for mc_ctrl outputs; instantiate alongside the controller.
module mc_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic       PCWr,
  input logic       IRWr,
  input logic       RFWr,
  input logic       DMWr,
  input logic [2:0] ALUctrl,
  input logic       retire,
  input logic [2:0] state
);

  a_no_pc_rf: assert property (@(posedge clk) !(PCWr && RFWr));

  a_rst_quiet: assert property (@(posedge clk)
    rst |-> (!PCWr && !IRWr && !RFWr && !DMWr && ALUctrl == 3'b000 && !retire));

  a_rst_fetch: assert property (@(posedge clk) rst |=> state == 3'd0);

  a_retire_state: assert property (@(posedge clk)
    (!rst && retire) |-> (state == 3'd1 || state == 3'd4 || state == 3'd5 || state == 3'd6));

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected outputs are queued per
// instruction and compared cycle by cycle against the controller.

module tb_mc_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr, IRWr, RFWr, DMWr;
  logic [2:0] ALUctrl;
  logic       BSel, ExtOp;
  logic [1:0] WRSel;
  logic       WDSel;
  logic [1:0] NPCOp;
  logic       retire;
  logic [2:0] state;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr), .ALUctrl(ALUctrl),
    .BSel(BSel), .ExtOp(ExtOp), .WRSel(WRSel), .WDSel(WDSel), .NPCOp(NPCOp),
    .retire(retire), .state(state)
  );

  mc_ctrl_chk u_chk (
    .clk(clk), .rst(rst), .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
    .ALUctrl(ALUctrl), .retire(retire), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       pcwr;
    logic       irwr;
    logic       rfwr;
    logic       dmwr;
    logic [2:0] alu;
    logic       bsel;
    logic       extop;
    logic [1:0] wrsel;
    logic       wdsel;
    logic [1:0] npcop;
    logic       retire;
  } exp_t;

  localparam logic [1:0] K_WB  = 2'd0;
  localparam logic [1:0] K_LW  = 2'd1;
  localparam logic [1:0] K_SW  = 2'd2;
  localparam logic [1:0] K_BEQ = 2'd3;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       legal;
    logic [1:0] kind;
    logic [2:0] alu;
    logic       bsel;
    logic       extop;
    logic [1:0] wrsel;
    logic       wdsel;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  int   instr_cnt = 0;
  int   retire_cnt = 0;
  int   both_cnt = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) begin
    if (mon_en && !rst) begin
      if (retire) retire_cnt <= retire_cnt + 1;
      if (PCWr && RFWr) both_cnt <= both_cnt + 1;
    end
  end

  // Reference decode for the random stream, written straight from the ISA table.
  function automatic vec_t ref_decode(input logic [5:0] o, input logic [5:0] f);
    vec_t v;
    v = '{o, f, 1'b0, 1'b0, K_WB, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0};
    if (o == 6'b000000 && f == 6'b100001) begin
      v.legal = 1'b1; v.alu = 3'b001; v.wrsel = 2'b01;
    end else if (o == 6'b000000 && f == 6'b100011) begin
      v.legal = 1'b1; v.alu = 3'b011; v.wrsel = 2'b01;
    end else if (o == 6'b001101) begin
      v.legal = 1'b1; v.alu = 3'b010; v.bsel = 1'b1;
    end else if (o == 6'b100011) begin
      v.legal = 1'b1; v.kind = K_LW; v.alu = 3'b110; v.bsel = 1'b1; v.extop = 1'b1; v.wdsel = 1'b1;
    end else if (o == 6'b101011) begin
      v.legal = 1'b1; v.kind = K_SW; v.alu = 3'b111; v.bsel = 1'b1; v.extop = 1'b1;
    end else if (o == 6'b000100) begin
      v.legal = 1'b1; v.kind = K_BEQ; v.alu = 3'b101; v.extop = 1'b1;
    end
    return v;
  endfunction

  function automatic exp_t dp_rec(input logic [2:0] st, input vec_t v);
    exp_t e;
    e = '0;
    e.state = st;
    e.alu = v.alu;
    e.bsel = v.bsel;
    e.extop = v.extop;
    e.wrsel = v.wrsel;
    e.wdsel = v.wdsel;
    return e;
  endfunction

  // Expand one instruction into its expected per-cycle records.
  task automatic push_instr(input vec_t v);
    exp_t e;
    e = '0; e.state = 3'd0; e.pcwr = 1'b1; e.irwr = 1'b1;
    sb_q.push_back(e);
    e = '0; e.state = 3'd1; e.retire = ~v.legal;
    sb_q.push_back(e);
    if (v.legal) begin
      if (v.kind == K_BEQ) begin
        e = dp_rec(3'd6, v); e.npcop = 2'b01; e.pcwr = v.zero; e.retire = 1'b1;
        sb_q.push_back(e);
      end else begin
        sb_q.push_back(dp_rec(3'd2, v));
        if (v.kind == K_LW) sb_q.push_back(dp_rec(3'd3, v));
        if (v.kind == K_SW) begin
          e = dp_rec(3'd4, v); e.dmwr = 1'b1; e.retire = 1'b1;
        end else begin
          e = dp_rec(3'd5, v); e.rfwr = 1'b1; e.retire = 1'b1;
        end
        sb_q.push_back(e);
      end
    end
  endtask

  // Called at a falling edge: compare mid-cycle, then advance to the next falling edge.
  task automatic check_cycle(input string name);
    exp_t e;
    exp_t a;
    e = sb_q.pop_front();
    #2;
    a = {state, PCWr, IRWr, RFWr, DMWr, ALUctrl, BSel, ExtOp, WRSel, WDSel, NPCOp, retire};
    checks++;
    if (a !== e) begin
      $display("FAIL %s: state %0d got %h expected %h", name, e.state, a, e);
    end else begin
      passed++;
    end
    @(negedge clk);
  endtask

  task automatic run_instr(input vec_t v, input string name);
    int n;
    op = v.op;
    funct = v.funct;
    zero = v.zero;
    push_instr(v);
    n = sb_q.size();
    for (int i = 0; i < n; i++) check_cycle(name);
    instr_cnt++;
  endtask

  vec_t tbl[10];
  exp_t z;

  initial begin
    tbl[0] = '{6'b000000, 6'b100001, 1'b0, 1'b1, K_WB,  3'b001, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[1] = '{6'b001101, 6'b000000, 1'b0, 1'b1, K_WB,  3'b010, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[2] = '{6'b100011, 6'b010101, 1'b0, 1'b1, K_LW,  3'b110, 1'b1, 1'b1, 2'b00, 1'b1};
    tbl[3] = '{6'b101011, 6'b000000, 1'b1, 1'b1, K_SW,  3'b111, 1'b1, 1'b1, 2'b00, 1'b0};
    tbl[4] = '{6'b000100, 6'b000000, 1'b1, 1'b1, K_BEQ, 3'b101, 1'b0, 1'b1, 2'b00, 1'b0};
    tbl[5] = '{6'b000100, 6'b000000, 1'b0, 1'b1, K_BEQ, 3'b101, 1'b0, 1'b1, 2'b00, 1'b0};
    tbl[6] = '{6'b111111, 6'b100001, 1'b0, 1'b0, K_WB,  3'b000, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[7] = '{6'b000000, 6'b100000, 1'b0, 1'b0, K_WB,  3'b000, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[8] = '{6'b000000, 6'b100011, 1'b1, 1'b1, K_WB,  3'b011, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[9] = '{6'b001101, 6'b100011, 1'b1, 1'b1, K_WB,  3'b010, 1'b1, 1'b0, 2'b00, 1'b0};

    rst = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0;
    repeat (3) @(negedge clk);
    z = '0;
    sb_q.push_back(z);
    check_cycle("reset_state");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

    // Abort an addu in EXE with a 3-cycle reset, then run a clean addu.
    op = tbl[0].op; funct = tbl[0].funct; zero = 1'b0;
    push_instr(tbl[0]);
    void'(sb_q.pop_back());
    void'(sb_q.pop_back());
    check_cycle("abort_fetch");
    check_cycle("abort_decode");
    rst = 1'b1;
    z = '0; z.state = 3'd2;
    sb_q.push_back(z);
    check_cycle("rst_in_exe");
    z = '0;
    sb_q.push_back(z);
    check_cycle("rst_hold1");
    sb_q.push_back(z);
    check_cycle("rst_hold2");
    rst = 1'b0;
    run_instr(tbl[0], "post_rst_addu");

    mon_en = 1'b1;
    instr_cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      logic [5:0] o;
      logic [5:0] f;
      vec_t v;
      f = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 7))
        0: begin o = 6'b000000; f = 6'b100001; end
        1: begin o = 6'b000000; f = 6'b100011; end
        2: o = 6'b001101;
        3: o = 6'b100011;
        4: o = 6'b101011;
        5: o = 6'b000100;
        6: o = 6'b000000;
        default: o = 6'($urandom_range(0, 63));
      endcase
      v = ref_decode(o, f);
      v.zero = 1'($urandom_range(0, 1));
      run_instr(v, "stream");
    end
    mon_en = 1'b0;
    @(negedge clk);

    checks++;
    if (retire_cnt != instr_cnt) begin
      $display("FAIL retire_count: got %0d required %0d", retire_cnt, instr_cnt);
    end else begin
      passed++;
    end
    checks++;
    if (both_cnt != 0) begin
      $display("FAIL pcwr_rfwr_overlap: got %0d required 0", both_cnt);
    end else begin
      passed++;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle main controller for the simple CPU datapath. Decodes the opcode and function fields of the latched instruction and sequences each instruction through fetch, decode, execute, memory and write-back. It drives the ALU's 3-bit operation select and all datapath write enables and multiplexer selects, and it consumes the ALU `zero` flag to resolve `beq`.

## Interface
Parameters:
- none; the ISA subset and encodings are fixed.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  6  instruction bits [31:26] from the IR.
- `funct`  in  6  instruction bits [5:0] from the IR.
- `zero`  in  1  ALU zero flag, combinational, same cycle.
- `PCWr`  out  1  PC write enable.
- `IRWr`  out  1  IR write enable.
- `RFWr`  out  1  register-file write enable.
- `DMWr`  out  1  data-memory write enable.
- `ALUctrl`  out  3  ALU operation: add 001, sub 011, ori 010, lw 110, sw 111, beq 101, idle 000.
- `BSel`  out  1  ALU B source: 0 = register rt, 1 = extended immediate.
- `ExtOp`  out  1  immediate extension: 0 = zero-extend, 1 = sign-extend.
- `WRSel`  out  2  write register: 00 = rt, 01 = rd, others reserved.
- `WDSel`  out  1  write data: 0 = ALU result, 1 = memory read data.
- `NPCOp`  out  2  next-PC source: 00 = PC+4, 01 = PC + (sext(imm)<<2), others reserved.
- `retire`  out  1  one-cycle pulse in the final cycle of every instruction.
- `state`  out  3  current state, for debug and verification.

## Operation
Supported instructions:
- addu: op 000000, funct 100001.
- subu: op 000000, funct 100011.
- ori: op 001101.
- lw: op 100011.
- sw: op 101011.
- beq: op 000100.
- Anything else is illegal and executes as a NOP.

States, with encodings:
- FETCH 0: `PCWr`=1, `IRWr`=1, `NPCOp`=00. Next state DECODE.
- DECODE 1: all enables 0. Next state:
  - addu/subu/ori/lw/sw → EXE.
  - beq → BRANCH.
  - illegal → FETCH, with `retire`=1.
- EXE 2: `ALUctrl` per instruction, `BSel`=1 for ori/lw/sw. Next state:
  - lw → MEM_RD.
  - sw → MEM_WR.
  - others → WB.
- MEM_RD 3: data-memory read. Next state WB.
- MEM_WR 4: `DMWr`=1, `retire`=1. Next state FETCH.
- WB 5: `RFWr`=1, `retire`=1. `WRSel`=01 for R-type, 00 otherwise; `WDSel`=1 for lw only. Next state FETCH.
- BRANCH 6: `ALUctrl`=101, `BSel`=0, `ExtOp`=1, `NPCOp`=01, `PCWr`=`zero`, `retire`=1. Next state FETCH.
- Encoding 7 is unreachable. If entered, next state is FETCH and all enables are 0.

Output rules:
- `ALUctrl`, `BSel`, `ExtOp`, `WRSel` and `WDSel` hold the instruction's values from EXE through the last state, so ALU and memory inputs stay stable.
- In FETCH and DECODE these outputs are 0, except `NPCOp` as listed above.
- `ExtOp`=0 for ori and 1 for lw/sw/beq.
- All outputs are combinational from `state`, `op`, `funct` and `zero`. Only `state` is registered.
- `op` and `funct` are stable outside FETCH because `IRWr` is asserted only in FETCH.

## Timing
Reset:
- While `rst`=1, all outputs except `state` are forced to 0 combinationally, including `ALUctrl`=000.
- On the first rising edge with `rst`=1, `state` becomes FETCH.
- `rst` is sampled every edge. Asserting it mid-instruction aborts the instruction, and no further enables assert.
- The first cycle after `rst` deasserts is FETCH.

Latency, in cycles from FETCH to retire inclusive:
- addu, subu, ori: 4.
- lw: 5.
- sw: 4.
- beq: 3.
- illegal: 2.

Branch behaviour:
- Taken and not-taken `beq` both take 3 cycles.
- The PC was already advanced to PC+4 in FETCH, so the branch target is relative to PC+4.

Other rules:
- Exactly one `retire` pulse per instruction.
- `PCWr` and `RFWr` are never both 1 in the same cycle.

## Test plan
- Reset: hold `rst`=1 for 3 cycles during EXE → all enables 0 and `ALUctrl`=000 while asserted; `state`=0 after the first edge; FETCH asserts `PCWr`=`IRWr`=1 in the first cycle after release.
- addu then ori: op 000000/funct 100001, then op 001101 → states 0,1,2,5 each; `ALUctrl` 001 then 010; `WRSel` 01 then 00; `BSel` 0 then 1; `ExtOp` 0 for ori; `retire` on cycles 4 and 8.
- lw then sw: lw → states 0,1,2,3,5 with `ALUctrl`=110 in states 2–5 and `WDSel`=1 in WB; sw → states 0,1,2,4 with `DMWr`=1 for one cycle, `ALUctrl`=111 and `RFWr` never asserted.
- beq taken and not taken: `zero`=1 → `PCWr`=1 and `NPCOp`=01 in BRANCH; `zero`=0 → `PCWr`=0. Both return to FETCH after 3 cycles with `ALUctrl`=101 in BRANCH.
- Illegal opcode 111111, and op 000000 with funct 100000 → DECODE→FETCH, `retire` in cycle 2, no `RFWr`/`DMWr`.
- Back-to-back random legal/illegal stream of 1000 instructions, checked against a reference model → exact state sequence per instruction, one `retire` per instruction, and `PCWr`/`RFWr` never both 1.
